trace_feeder: RTL

Upstream stage of the L1 cache simulator. Accepts 16-bit memory-trace addresses over an AXI4-Stream slave port and buffers them in a small FIFO. Presents them one at a time to the cache top level as `memory_trace`/`trace_ready`, holding each trace until the cache signals completion. Also counts completed accesses and flags end of stream.

---
 rtl/cache_sim_pkg.sv | 17 +
 rtl/trace_fifo.sv | 48 ++++
 rtl/trace_feeder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cache_sim_pkg.sv
// Shared types for the L1 cache simulator front end: trace width, FIFO entry
// layout and the feeder FSM state encoding.
package cache_sim_pkg;

   localparam int TRACE_W = 16;

   typedef struct packed {
      logic               last;
      logic [TRACE_W-1:0] addr;
   } trace_entry_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } feeder_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries. Pointers carry one extra bit so that
// full and empty are told apart without a separate occupancy counter.
module trace_fifo
   import cache_sim_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  trace_entry_t din,
   input  logic         pop,
   output trace_entry_t dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   trace_entry_t  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A push while full is dropped even if a pop frees a slot this cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/trace_feeder.sv
// Buffers AXI4-Stream trace addresses and hands them one at a time to the cache.
// Optional per-access watchdog is enabled with TRACE_FEEDER_TIMEOUT_EN.
module trace_feeder
   import cache_sim_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [TRACE_W-1:0] s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic               s_axis_tlast,
   output logic [TRACE_W-1:0] memory_trace,
   output logic               trace_ready,
   input  logic               access_done,
   output logic [15:0]        trace_count,
   output logic               stream_done,
   output logic               timeout_err
);

   feeder_state_e state;
   feeder_state_e state_nxt;
   trace_entry_t  fifo_din;
   trace_entry_t  fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          complete;
   logic          counted;
   logic          cur_last;
   logic          expired;

   assign s_axis_tready = ~fifo_full;
   assign push          = s_axis_tvalid & ~fifo_full;
   assign fifo_din      = trace_entry_t'({s_axis_tlast, s_axis_tdata});

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!fifo_empty) state_nxt = ST_ISSUE;
         ST_ISSUE: if (access_done || expired) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // trace_ready decodes the state register, so reset drops it asynchronously.
   always_comb begin
      trace_ready = 1'b0;
      pop         = 1'b0;
      complete    = 1'b0;
      counted     = 1'b0;
      case (state)
         ST_IDLE:  pop = ~fifo_empty;
         ST_ISSUE: begin
            trace_ready = 1'b1;
            complete    = access_done | expired;
            counted     = access_done;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memory_trace <= '0;
         cur_last     <= 1'b0;
      end else if (pop) begin
         memory_trace <= fifo_dout.addr;
         cur_last     <= fifo_dout.last;
      end
   end

   // A push after a finished stream opens a new one; that restart beats any increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trace_count <= '0;
         stream_done <= 1'b0;
      end else if (push && stream_done) begin
         trace_count <= '0;
         stream_done <= 1'b0;
      end else begin
         if (counted && trace_count != 16'hFFFF) trace_count <= trace_count + 16'd1;
         if (complete && cur_last) stream_done <= 1'b1;
      end
   end

`ifdef TRACE_FEEDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           timer <= '0;
      else if (state == ST_ISSUE && !complete) timer <= timer + TW'(1);
      else                                  timer <= '0;
   end

   assign expired = (state == ST_ISSUE) && (timer == TW'(TIMEOUT_CYCLES - 1));

   // access_done on the expiry edge wins and suppresses the error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        timeout_err <= 1'b0;
      else if (expired && !access_done) timeout_err <= 1'b1;
   end
`else
   assign expired     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule
